// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared definitions for the PE partial-sum accumulator. It holds
//               the accumulator FSM state encoding, the 32-bit signed limits
//               used for saturation, and a signed-overflow helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    // Accumulator control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,    // waiting for the first beat of a new accumulation
        ACC  = 2'd1,    // adding the remaining beats
        OUT  = 2'd2     // holding the result until downstream takes it
    } pe_state_t;

    // Signed 32-bit clamp values.
    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    // Two's-complement overflow: both operands have the same sign and the
    // sum's sign differs from it.
    function automatic logic signed_add_ovf(input logic a_msb,
                                            input logic b_msb,
                                            input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_sadd.sv
`default_nettype none
// ============================================================================
// Module      : pe_sadd
// Description : Combinational signed adder with overflow flag. When the
//               PE_PSUM_SAT_EN macro is defined an overflowing sum is clamped
//               to the most positive / most negative value; otherwise the sum
//               wraps modulo 2^DATA_W. The overflow flag is reported in both
//               builds.
// Ports       : i_a, i_b  - signed operands (DATA_W)
//               o_sum     - wrapped or saturated sum (DATA_W)
//               o_ovf     - signed overflow occurred
// Config      : PE_PSUM_SAT_EN (macro) - enables saturation
// Revision    : 1.0 - initial release
// ============================================================================
module pe_sadd
    import pe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_ovf
);

    logic [DATA_W-1:0] w_raw;
    logic              w_ovf;

    // Plain modulo-2^DATA_W sum; the carry out is intentionally discarded.
    assign w_raw = i_a + i_b;
    assign w_ovf = signed_add_ovf(i_a[DATA_W-1], i_b[DATA_W-1], w_raw[DATA_W-1]);

`ifdef PE_PSUM_SAT_EN
    // For the standard 32-bit datapath use the shared limits; other widths
    // derive the equivalent clamp values.
    localparam logic [DATA_W-1:0] c_POS_SAT = (DATA_W == 32) ? DATA_W'(INT32_MAX)
                                            : {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_NEG_SAT = (DATA_W == 32) ? DATA_W'(INT32_MIN)
                                            : {1'b1, {(DATA_W-1){1'b0}}};

    // On overflow both operands share a sign, so i_a's sign selects the rail.
    assign o_sum = w_ovf ? (i_a[DATA_W-1] ? c_NEG_SAT : c_POS_SAT) : w_raw;
`else
    assign o_sum = w_raw;
`endif

    assign o_ovf = w_ovf;

endmodule : pe_sadd
`default_nettype wire

// File: rtl/pe_psum_acc.sv
`default_nettype none
// ============================================================================
// Module      : pe_psum_acc
// Description : Partial-sum accumulator behind a 32-lane adder tree. It collects
//               cfg_len signed beats (0 counts as 1), adds them, and presents
//               the result with a sticky signed-overflow flag on a
//               valid/ready output. The result is held until it is accepted.
//               No new beat is taken while a result is pending.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_vld/in_rdy      - input beat handshake
//               in_data            - signed beat value (DATA_W)
//               cfg_len            - beats per result, sampled on first beat
//               out_vld/out_rdy    - result handshake
//               out_data           - accumulated signed result (DATA_W)
//               out_ovf            - overflow seen during this accumulation
// Config      : PE_PSUM_SAT_EN (macro) - saturate instead of wrap, see pe_sadd
// Revision    : 1.0 - initial release
// ============================================================================
module pe_psum_acc
    import pe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    pe_state_t         r_state;
    logic [DATA_W-1:0] r_acc;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic              r_ovf;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_ovf;

    logic              w_beat;
    logic [LEN_W-1:0]  w_len_first;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_sum;
    logic              w_add_ovf;
    logic              w_ovf_nxt;

    // Ready is withheld while a result is pending and throughout reset so no
    // beat can be accepted into a state that is about to be cleared.
    assign in_rdy      = ~rst & (r_state != OUT);
    assign w_beat      = in_vld & in_rdy;

    // A zero length would never complete; it is treated as a single beat.
    assign w_len_first = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign w_cnt_nxt   = r_cnt + LEN_W'(1);
    assign w_ovf_nxt   = r_ovf | w_add_ovf;

    pe_sadd #(
        .DATA_W (DATA_W)
    ) u_sadd (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // Control, accumulator and output register. The output register is loaded
    // on the edge that accepts the final beat, so the result appears exactly
    // one cycle later and stays frozen outside OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len      <= LEN_W'(1);
            r_ovf      <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        // First beat seeds the accumulator directly.
                        r_acc <= in_data;
                        r_len <= w_len_first;
                        r_cnt <= LEN_W'(1);
                        r_ovf <= 1'b0;
                        if (w_len_first == LEN_W'(1)) begin
                            r_state    <= OUT;
                            r_out_vld  <= 1'b1;
                            r_out_data <= in_data;
                            r_out_ovf  <= 1'b0;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end

                ACC: begin
                    if (w_beat) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= w_ovf_nxt;
                        if (w_cnt_nxt == r_len) begin
                            r_state    <= OUT;
                            r_out_vld  <= 1'b1;
                            r_out_data <= w_sum;
                            r_out_ovf  <= w_ovf_nxt;
                        end
                    end
                end

                OUT: begin
                    if (out_rdy) begin
                        r_state   <= IDLE;
                        r_out_vld <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end

    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign out_ovf  = r_out_ovf;

endmodule : pe_psum_acc
`default_nettype wire

// File: tb/tb_pe_psum_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_psum_acc
// Description : Self-checking bench for pe_psum_acc. A behavioural model built
//               on exact 64-bit integer sums predicts the outputs every cycle;
//               directed scenarios add hand-computed literal expectations.
// Config      : PE_PSUM_SAT_EN (macro) - selects saturating expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_psum_acc;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

`ifdef PE_PSUM_SAT_EN
    localparam bit          c_SAT        = 1'b1;
    localparam logic [31:0] c_EXP_POSOVF = 32'h7FFF_FFFF;
    localparam logic [31:0] c_EXP_NEGOVF = 32'h8000_0000;
    localparam logic [31:0] c_EXP_STICKY = 32'h7FFF_FFFF;
`else
    localparam bit          c_SAT        = 1'b0;
    localparam logic [31:0] c_EXP_POSOVF = 32'h8000_0000;
    localparam logic [31:0] c_EXP_NEGOVF = 32'h7FFF_FFFF;
    localparam logic [31:0] c_EXP_STICKY = 32'h8000_0005;
`endif

    localparam longint c_MAXL = 64'sd2147483647;
    localparam longint c_MINL = -64'sd2147483648;

    logic              clk;
    logic              rst;
    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] in_data;
    logic [LEN_W-1:0]  cfg_len;
    logic              out_vld;
    logic              out_rdy;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;

    int n_vec = 0;
    int n_err = 0;

    pe_psum_acc #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .cfg_len  (cfg_len),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: list-free running sum kept as an exact integer,
    // then reduced to 32 bits by wrapping or clamping.
    // ------------------------------------------------------------------
    bit          m_en = 1'b0;
    bit          m_pend, m_busy, m_ov;
    int          m_len, m_cnt;
    longint      m_acc, m_exact;
    logic [31:0] m_out_data;
    bit          m_out_ovf;

    always @(negedge clk) begin
        if (m_en) begin
            chk("mdl_out_vld",  {31'b0, out_vld}, {31'b0, m_pend});
            chk("mdl_in_rdy",   {31'b0, in_rdy},  {31'b0, (!rst && !m_pend)});
            chk("mdl_out_data", out_data, m_out_data);
            chk("mdl_out_ovf",  {31'b0, out_ovf}, {31'b0, m_out_ovf});

            // Predict the effect of the coming rising edge from stable inputs.
            if (rst) begin
                m_pend = 0; m_busy = 0; m_out_data = '0; m_out_ovf = 0;
            end else if (m_pend) begin
                if (out_rdy) m_pend = 0;
            end else if (in_vld) begin
                if (!m_busy) begin
                    m_acc = longint'($signed(in_data));
                    m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
                    m_cnt = 1;
                    m_ov  = 0;
                end else begin
                    m_exact = m_acc + longint'($signed(in_data));
                    if (m_exact > c_MAXL || m_exact < c_MINL) begin
                        m_ov = 1;
                        if (c_SAT) m_acc = (m_exact > c_MAXL) ? c_MAXL : c_MINL;
                        else       m_acc = longint'($signed(m_exact[31:0]));
                    end else begin
                        m_acc = m_exact;
                    end
                    m_cnt++;
                end
                if (m_cnt == m_len) begin
                    m_pend = 1; m_busy = 0;
                    m_out_data = m_acc[31:0];
                    m_out_ovf  = m_ov;
                end else begin
                    m_busy = 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus. Inputs change 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic push(input logic [31:0] d, input logic [15:0] l);
        in_vld  = 1'b1;
        in_data = d;
        cfg_len = l;
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Result must be visible in the cycle right after the last accepted beat;
    // the following edge (out_rdy high) completes the handshake.
    task automatic expect_now(input string name, input logic [31:0] d, input logic o);
        in_vld = 1'b0;
        @(negedge clk);
        chk({name, "_vld"},  {31'b0, out_vld}, 32'd1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_ovf"},  {31'b0, out_ovf}, {31'b0, o});
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_data = '0; cfg_len = '0; out_rdy = 1'b1;
        m_pend = 0; m_busy = 0; m_ov = 0; m_len = 1; m_cnt = 0; m_acc = 0;
        m_exact = 0; m_out_data = '0; m_out_ovf = 0;
        @(posedge clk);
        m_en = 1'b1;
        @(negedge clk);
        chk("rst_out_vld",  {31'b0, out_vld}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_rdy",   {31'b0, in_rdy}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Basic four-beat run.
        push(32'd10, 16'd4); push(32'd20, 16'd4); push(-32'sd5, 16'd4); push(32'd7, 16'd4);
        expect_now("basic", 32'd32, 1'b0);

        // Single-beat runs with length 0 and 1.
        push(32'hFFFF_FFFF, 16'd0);
        expect_now("len0", 32'hFFFF_FFFF, 1'b0);
        push(32'hFFFF_FFFF, 16'd1);
        expect_now("len1", 32'hFFFF_FFFF, 1'b0);

        // Overflow in both directions and stickiness.
        push(32'h7FFF_FFFF, 16'd2); push(32'd1, 16'd2);
        expect_now("ovf_pos", c_EXP_POSOVF, 1'b1);
        push(32'h8000_0000, 16'd2); push(32'hFFFF_FFFF, 16'd2);
        expect_now("ovf_neg", c_EXP_NEGOVF, 1'b1);
        push(32'h7FFF_FFFF, 16'd3); push(32'd1, 16'd3); push(32'd5, 16'd3);
        expect_now("ovf_sticky", c_EXP_STICKY, 1'b1);
        push(32'd3, 16'd2); push(32'd4, 16'd2);
        expect_now("ovf_cleared", 32'd7, 1'b0);

        // Backpressure: result held, beats offered meanwhile are ignored.
        out_rdy = 1'b0;
        push(32'd100, 16'd3); push(32'd200, 16'd3); push(32'd300, 16'd3);
        in_data = 32'd999; cfg_len = 16'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_vld",  {31'b0, out_vld}, 32'd1);
            chk("bp_data", out_data, 32'd600);
            chk("bp_rdy",  {31'b0, in_rdy}, 32'd0);
        end
        step();
        out_rdy = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        chk("bp_hold_vld", {31'b0, out_vld}, 32'd1);
        @(negedge clk);
        chk("bp_release_vld", {31'b0, out_vld}, 32'd0);
        step();
        push(32'd3, 16'd2); push(32'd4, 16'd2);
        expect_now("bp_next", 32'd7, 1'b0);

        // Bubbles and a cfg_len change after the first beat.
        push(32'd11, 16'd3);
        in_vld = 1'b0; cfg_len = 16'd8;
        step(); step();
        push(32'd22, 16'd8);
        in_vld = 1'b0;
        step();
        push(32'd33, 16'd8);
        expect_now("gaps", 32'd66, 1'b0);

        // Reset in the middle of an accumulation discards it.
        push(32'd5, 16'd4); push(32'd6, 16'd4);
        in_vld = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_vld", {31'b0, out_vld}, 32'd0);
        end
        step();
        push(32'd1, 16'd4); push(32'd1, 16'd4); push(32'd1, 16'd4); push(32'd1, 16'd4);
        expect_now("after_rst", 32'd4, 1'b0);

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pe_psum_acc
`default_nettype wire
